// File: rtl/xge_link_ctrl.sv
// 10GbE link bring-up controller: sequences SerDes resets, lock waits, link supervision and retry backoff.
// Optional statistics counters are enabled by defining XGE_LINK_CTRL_STATS_EN.
module xge_link_ctrl #(
  parameter int RST_CYC      = 16,
  parameter int LOCK_TIMEOUT = 1562500,
  parameter int DEBOUNCE     = 64,
  parameter int BACKOFF_CYC  = 156250
) (
  input  logic        xge_clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        sfp_los,
  input  logic        pll_lock,
  input  logic        cdr_lock,
  input  logic        signal_detected,
  input  logic        block_lock,
  output logic        serdes_tx_rstn,
  output logic        serdes_rx_rstn,
  output logic        sfp_tx_disable,
  output logic        mac_enable,
  output logic        link_up,
  output logic        ber_clear,
  output logic        blkerr_clear,
  output logic [2:0]  state,
`ifdef XGE_LINK_CTRL_STATS_EN
  output logic [15:0] link_drop_cnt,
  output logic [15:0] los_event_cnt,
`endif
  output logic [7:0]  retry_cnt
);

  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    TX_RST   = 3'd1,
    PLL_WAIT = 3'd2,
    RX_RST   = 3'd3,
    CDR_WAIT = 3'd4,
    UP       = 3'd5,
    BACKOFF  = 3'd6
  } state_t;

  // Limits are "last cycle" values: the timer reads 0 on the first cycle in a state.
  localparam logic [23:0] RST_LIM  = 24'(RST_CYC - 1);
  localparam logic [23:0] LOCK_LIM = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] BACK_LIM = 24'(BACKOFF_CYC - 1);
  localparam logic [7:0]  DBNC_LIM = 8'(DEBOUNCE - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [23:0] sat_inc24(input logic [23:0] v);
    return (v == 24'hFFFFFF) ? v : v + 24'd1;
  endfunction

`ifdef XGE_LINK_CTRL_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  logic [5:0]  meta_p0, sync_p1;
  logic        en_s, los_s, pll_s, cdr_s, sd_s, blk_s;
  state_t      st, st_nxt;
  logic [23:0] timer;
  logic [7:0]  lost_cnt;
  logic        tx_dis_d, tx_rstn_d, rx_rstn_d, mac_d, link_d;

  assign {en_s, los_s, pll_s, cdr_s, sd_s, blk_s} = sync_p1;
  assign state = st;

  always_comb begin
    st_nxt = st;
    case (st)
      DISABLED: if (en_s) st_nxt = TX_RST;
      TX_RST:   if (timer >= RST_LIM) st_nxt = PLL_WAIT;
      PLL_WAIT: begin
        if (pll_s) st_nxt = RX_RST;
        else if (timer >= LOCK_LIM) st_nxt = BACKOFF;
      end
      RX_RST:   if (timer >= RST_LIM && !los_s && sd_s) st_nxt = CDR_WAIT;
      CDR_WAIT: begin
        if (cdr_s && blk_s) st_nxt = UP;
        else if (timer >= LOCK_LIM) st_nxt = BACKOFF;
      end
      UP:       if (los_s || !pll_s || (!blk_s && lost_cnt >= DBNC_LIM)) st_nxt = BACKOFF;
      BACKOFF:  if (timer >= BACK_LIM) st_nxt = TX_RST;
      default:  st_nxt = DISABLED;
    endcase
    if (!en_s) st_nxt = DISABLED;
  end

  // Outputs decoded from the next state so they register on the edge that enters it.
  always_comb begin
    tx_dis_d  = 1'b0;
    tx_rstn_d = 1'b1;
    rx_rstn_d = 1'b0;
    mac_d     = 1'b0;
    link_d    = 1'b0;
    case (st_nxt)
      DISABLED: begin tx_dis_d = 1'b1; tx_rstn_d = 1'b0; end
      TX_RST:   tx_rstn_d = 1'b0;
      CDR_WAIT: rx_rstn_d = 1'b1;
      UP:       begin rx_rstn_d = 1'b1; mac_d = 1'b1; link_d = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge xge_clk or negedge rstn) begin
    if (!rstn) begin
      meta_p0        <= '0;
      sync_p1        <= '0;
      st             <= DISABLED;
      timer          <= '0;
      lost_cnt       <= '0;
      retry_cnt      <= '0;
      sfp_tx_disable <= 1'b1;
      serdes_tx_rstn <= 1'b0;
      serdes_rx_rstn <= 1'b0;
      mac_enable     <= 1'b0;
      link_up        <= 1'b0;
      ber_clear      <= 1'b0;
      blkerr_clear   <= 1'b0;
    end else begin
      // stage p0 -> p1: two-flop synchroniser on all asynchronous status inputs
      meta_p0 <= {enable, sfp_los, pll_lock, cdr_lock, signal_detected, block_lock};
      sync_p1 <= meta_p0;
      // FSM and state-tied outputs
      st             <= st_nxt;
      timer          <= (st_nxt != st) ? 24'd0 : sat_inc24(timer);
      lost_cnt       <= (st == UP && !blk_s) ? lost_cnt + 8'd1 : 8'd0;
      sfp_tx_disable <= tx_dis_d;
      serdes_tx_rstn <= tx_rstn_d;
      serdes_rx_rstn <= rx_rstn_d;
      mac_enable     <= mac_d;
      link_up        <= link_d;
      ber_clear      <= (st_nxt == UP) && (st != UP);
      blkerr_clear   <= (st_nxt == UP) && (st != UP);
      if (st == DISABLED && en_s) retry_cnt <= '0;
      else if (st_nxt == BACKOFF && st != BACKOFF) retry_cnt <= sat_inc8(retry_cnt);
    end
  end

`ifdef XGE_LINK_CTRL_STATS_EN
  logic los_prev;

  always_ff @(posedge xge_clk or negedge rstn) begin
    if (!rstn) begin
      los_prev      <= 1'b0;
      link_drop_cnt <= '0;
      los_event_cnt <= '0;
    end else begin
      los_prev <= los_s;
      if (st == UP && st_nxt == BACKOFF) link_drop_cnt <= sat_inc16(link_drop_cnt);
      if (los_s && !los_prev) los_event_cnt <= sat_inc16(los_event_cnt);
    end
  end
`endif

endmodule
